// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accum_pkg
//  Description : Shared constants and types for the accumulator-bank arbiter.
//                Holds the default geometry of one accumulator bank group,
//                the arbiter state encoding and the requester id type.
//  Revision    : 1.0  initial release
// ============================================================================
package accum_pkg;

    localparam int c_NUM_REQ      = 4;
    localparam int c_NUM_BANKS    = 4;
    localparam int c_ADDR_WIDTH   = 9;
    localparam int c_DATA_WIDTH   = 64;
    localparam int c_RD_TAG_DEPTH = 4;
    localparam int c_REQ_ID_W     = $clog2(c_NUM_REQ);
    localparam int c_PERF_CNT_W   = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } arb_state_e;

    typedef logic [c_REQ_ID_W-1:0] req_id_t;

endpackage
`default_nettype wire

// File: rtl/accum_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : accum_tag_fifo
//  Description : Synchronous FIFO of requester ids. Remembers which requester
//                issued each outstanding read so returning data can be routed
//                back in order. Push while full and pop while empty are
//                ignored; a simultaneous push and pop at full is accepted.
//  Revision    : 1.0  initial release
//  Ports       : clk, rstn       clock / asynchronous active-low reset
//                push, push_data enqueue a requester id
//                pop             dequeue the head entry
//                head            current head id (valid when !empty)
//                full, empty     occupancy flags (from registered count)
//                count           number of stored entries
// ============================================================================
module accum_tag_fifo
    import accum_pkg::*;
#(
    parameter int DEPTH = c_RD_TAG_DEPTH,
    parameter int WIDTH = $bits(req_id_t),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Full is taken from the registered count, so a push at full is only
    // accepted together with a pop that frees the slot.
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/accum_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : accum_arbiter
//  Description : Round-robin arbiter sharing one accumulator bank group
//                between NUM_REQ requesters. The winning command passes
//                through combinationally; a granted write locks the bus until
//                its data beat is accepted; read responses are routed back to
//                their issuer in order through a tag FIFO.
//  Revision    : 1.0  initial release
//  Ports       : clk, rstn                     clock / async active-low reset
//                s_valid/s_ready/s_rw/s_accum_en/s_mask/s_addr
//                                              per-requester command channel
//                s_wvalid/s_wready/s_wdata     per-requester write channel
//                s_rvalid/s_rdata              routed read valid, broadcast data
//                m_valid/m_ready/m_rw/m_accum_en/m_mask/m_addr
//                                              downstream command channel
//                m_wvalid/m_wready/m_wdata     downstream write channel
//                m_rvalid/m_rdata              downstream read return
//                err                           sticky: read return, no tag
//                perf_grants                   per-requester 16-bit saturating
//                                              grant counters, only present
//                                              when ACCUM_ARB_PERF_EN is defined
// ============================================================================
module accum_arbiter
    import accum_pkg::*;
#(
    parameter int NUM_REQ      = c_NUM_REQ,
    parameter int NUM_BANKS    = c_NUM_BANKS,
    parameter int ADDR_WIDTH   = c_ADDR_WIDTH,
    parameter int DATA_WIDTH   = c_DATA_WIDTH,
    parameter int RD_TAG_DEPTH = c_RD_TAG_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [NUM_REQ-1:0]                    s_valid,
    output logic [NUM_REQ-1:0]                    s_ready,
    input  logic [NUM_REQ-1:0]                    s_rw,
    input  logic [NUM_REQ-1:0]                    s_accum_en,
    input  logic [NUM_REQ*NUM_BANKS-1:0]          s_mask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]         s_addr,
    input  logic [NUM_REQ-1:0]                    s_wvalid,
    output logic [NUM_REQ-1:0]                    s_wready,
    input  logic [NUM_REQ*NUM_BANKS*DATA_WIDTH-1:0] s_wdata,
    output logic [NUM_REQ-1:0]                    s_rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]       s_rdata,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic                                  m_rw,
    output logic                                  m_accum_en,
    output logic [NUM_BANKS-1:0]                  m_mask,
    output logic [ADDR_WIDTH-1:0]                 m_addr,
    output logic                                  m_wvalid,
    input  logic                                  m_wready,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]       m_wdata,
    input  logic                                  m_rvalid,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]       m_rdata,
    output logic                                  err
`ifdef ACCUM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*c_PERF_CNT_W-1:0]       perf_grants
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int WD_W  = NUM_BANKS * DATA_WIDTH;
    localparam int CNT_W = $clog2(RD_TAG_DEPTH) + 1;

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic              err_q, err_d;

    logic [NUM_REQ-1:0] w_eligible;
    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_idx;
    logic               w_push;
    logic               w_pop;
    logic [ID_W-1:0]    w_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [CNT_W-1:0]   w_unused_tag_count;

    accum_tag_fifo #(
        .DEPTH (RD_TAG_DEPTH),
        .WIDTH (ID_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_push),
        .push_data (w_winner),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_unused_tag_count)
    );

    // A read can only win while a tag slot is free; writes are always
    // eligible. Blocked readers are simply skipped in the rotation.
    assign w_eligible = s_valid & (s_rw | {NUM_REQ{~w_fifo_full}});

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!w_found && w_eligible[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Command / write-data channel control. Handshake outputs are gated with
    // rstn so nothing is presented downstream while reset is held.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        s_ready    = '0;
        s_wready   = '0;
        m_valid    = 1'b0;
        m_rw       = 1'b0;
        m_accum_en = 1'b0;
        m_mask     = '0;
        m_addr     = '0;
        m_wvalid   = 1'b0;
        m_wdata    = '0;
        w_push     = 1'b0;
        if (rstn) begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        m_valid           = 1'b1;
                        m_rw              = s_rw[w_winner];
                        m_accum_en        = s_accum_en[w_winner];
                        m_mask            = s_mask[w_winner*NUM_BANKS +: NUM_BANKS];
                        m_addr            = s_addr[w_winner*ADDR_WIDTH +: ADDR_WIDTH];
                        s_ready[w_winner] = m_ready;
                        if (m_ready) begin
                            rr_ptr_d = (w_winner == ID_W'(NUM_REQ - 1)) ? '0
                                                                        : w_winner + ID_W'(1);
                            if (s_rw[w_winner]) begin
                                owner_d = w_winner;
                                state_d = WDATA;
                            end else begin
                                w_push = 1'b1;
                            end
                        end
                    end
                end
                WDATA: begin
                    m_wvalid          = s_wvalid[owner_q];
                    m_wdata           = s_wdata[owner_q*WD_W +: WD_W];
                    s_wready[owner_q] = m_wready;
                    if (m_wvalid && m_wready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read return routing: the FIFO head names the requester that owns the
    // returning beat. A return with no tag outstanding sets the sticky error.
    always_comb begin
        s_rvalid = '0;
        s_rdata  = m_rdata;
        w_pop    = rstn & m_rvalid & ~w_fifo_empty;
        if (w_pop) begin
            s_rvalid[w_head] = 1'b1;
        end
        err_d = err_q | (m_rvalid & w_fifo_empty);
    end

    assign err = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
        end
    end

`ifdef ACCUM_ARB_PERF_EN
    // s_ready is only ever high on a completed command handshake.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf
        logic [c_PERF_CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (s_ready[gi] && (cnt_q != {c_PERF_CNT_W{1'b1}})) begin
                cnt_d = cnt_q + c_PERF_CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign perf_grants[gi*c_PERF_CNT_W +: c_PERF_CNT_W] = cnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_accum_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_arbiter
//  Description : Randomised scoreboard bench for accum_arbiter. A driver
//                issues requester traffic and downstream responses, predicts
//                each transfer with a transaction-level model and queues it;
//                a monitor pops and compares whenever the DUT shows a
//                transfer.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_accum_arbiter;

    localparam int NR  = 4;
    localparam int NB  = 4;
    localparam int AW  = 9;
    localparam int DW  = 64;
    localparam int TD  = 4;
    localparam int WDW = NB * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rstn;
    logic [NR-1:0]        s_valid, s_ready, s_rw, s_accum_en;
    logic [NR*NB-1:0]     s_mask;
    logic [NR*AW-1:0]     s_addr;
    logic [NR-1:0]        s_wvalid, s_wready, s_rvalid;
    logic [NR*WDW-1:0]    s_wdata;
    logic [WDW-1:0]       s_rdata;
    logic                 m_valid, m_ready, m_rw, m_accum_en;
    logic [NB-1:0]        m_mask;
    logic [AW-1:0]        m_addr;
    logic                 m_wvalid, m_wready;
    logic [WDW-1:0]       m_wdata;
    logic                 m_rvalid;
    logic [WDW-1:0]       m_rdata;
    logic                 err;
`ifdef ACCUM_ARB_PERF_EN
    logic [NR*16-1:0]     perf_grants;
`endif

    accum_arbiter dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_rw       (s_rw),
        .s_accum_en (s_accum_en),
        .s_mask     (s_mask),
        .s_addr     (s_addr),
        .s_wvalid   (s_wvalid),
        .s_wready   (s_wready),
        .s_wdata    (s_wdata),
        .s_rvalid   (s_rvalid),
        .s_rdata    (s_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_rw       (m_rw),
        .m_accum_en (m_accum_en),
        .m_mask     (m_mask),
        .m_addr     (m_addr),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_wdata    (m_wdata),
        .m_rvalid   (m_rvalid),
        .m_rdata    (m_rdata),
        .err        (err)
`ifdef ACCUM_ARB_PERF_EN
        ,
        .perf_grants(perf_grants)
`endif
    );

    typedef struct {
        int           cyc;
        int           id;
        bit           rw;
        bit           acc;
        logic [NB-1:0] mask;
        logic [AW-1:0] addr;
    } cmd_t;

    typedef struct {
        int            cyc;
        int            id;
        logic [WDW-1:0] data;
    } beat_t;

    cmd_t  cmd_q[$];
    beat_t wr_q[$];
    beat_t rd_q[$];
    cmd_t  ce;
    beat_t be;

    // Requester agents
    bit             pend  [NR];
    bit             c_rw  [NR];
    bit             c_acc [NR];
    logic [NB-1:0]  c_mask[NR];
    logic [AW-1:0]  c_addr[NR];
    logic [WDW-1:0] c_wd  [NR];
    bit             wpend [NR];
    int             wdly  [NR];

    // Transaction-level reference state
    bit  mdl_locked;
    int  mdl_owner;
    int  mdl_rr;
    int  tags[$];
    bit  mdl_err;

    // Per-cycle expectations handed to the monitor
    bit  exp_err;
    bit  exp_mv;
    bit  exp_mwv;
    bit  in_reset;
    bit  rst_req;
    int  cyc;

    int  p_cmd, p_ret, p_rd;
    bit  force_bad;

    int  total = 0;
    int  bad   = 0;

    function automatic logic [WDW-1:0] rand_wide();
        logic [WDW-1:0] v;
        for (int k = 0; k < WDW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [WDW-1:0] got, input logic [WDW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mdl_locked = 1'b0;
        mdl_owner  = 0;
        mdl_rr     = 0;
        mdl_err    = 1'b0;
        tags.delete();
        for (int i = 0; i < NR; i++) wpend[i] = 1'b0;
    endtask

    task automatic step();
        int win;
        int j;
        int n_tags;
        int new_tag;
        int h;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_req) begin
            rstn     = 1'b0;
            in_reset = 1'b1;
            model_reset();
        end else begin
            rstn     = 1'b1;
            in_reset = 1'b0;
        end

        for (int i = 0; i < NR; i++) begin
            if (!pend[i] && !wpend[i] && ($urandom_range(99) < p_cmd)) begin
                pend[i]   = 1'b1;
                c_rw[i]   = ($urandom_range(99) >= p_rd);
                c_acc[i]  = 1'($urandom_range(1));
                c_mask[i] = NB'($urandom);
                c_addr[i] = AW'($urandom);
                c_wd[i]   = rand_wide();
            end
            s_valid[i]          = pend[i];
            s_rw[i]             = c_rw[i];
            s_accum_en[i]       = c_acc[i];
            s_mask[i*NB +: NB]  = c_mask[i];
            s_addr[i*AW +: AW]  = c_addr[i];
            if (wpend[i]) begin
                s_wvalid[i] = (wdly[i] == 0);
                if (wdly[i] > 0) wdly[i]--;
                s_wdata[i*WDW +: WDW] = c_wd[i];
            end else begin
                s_wvalid[i] = 1'($urandom_range(1));
                s_wdata[i*WDW +: WDW] = rand_wide();
            end
        end
        m_ready  = ($urandom_range(99) < 75);
        m_wready = ($urandom_range(99) < 70);
        m_rvalid = force_bad || ((tags.size() > 0) && ($urandom_range(99) < p_ret));
        m_rdata  = rand_wide();

        if (in_reset) return;

        exp_err = mdl_err;
        exp_mv  = 1'b0;
        exp_mwv = 1'b0;
        n_tags  = tags.size();
        new_tag = -1;
        if (!mdl_locked) begin
            win = -1;
            for (int k = 0; k < NR; k++) begin
                j = (mdl_rr + k) % NR;
                if (win < 0 && pend[j] && (c_rw[j] || n_tags < TD)) win = j;
            end
            exp_mv = (win >= 0);
            if (win >= 0 && m_ready) begin
                cmd_q.push_back('{cyc, win, c_rw[win], c_acc[win], c_mask[win], c_addr[win]});
                mdl_rr    = (win + 1) % NR;
                pend[win] = 1'b0;
                if (c_rw[win]) begin
                    mdl_locked = 1'b1;
                    mdl_owner  = win;
                    wpend[win] = 1'b1;
                    wdly[win]  = int'($urandom_range(3));
                end else begin
                    new_tag = win;
                end
            end
        end else begin
            exp_mwv = s_wvalid[mdl_owner];
            if (s_wvalid[mdl_owner] && m_wready) begin
                wr_q.push_back('{cyc, mdl_owner, c_wd[mdl_owner]});
                mdl_locked       = 1'b0;
                wpend[mdl_owner] = 1'b0;
            end
        end
        if (m_rvalid) begin
            if (n_tags > 0) begin
                h = tags.pop_front();
                rd_q.push_back('{cyc, h, m_rdata});
            end else begin
                mdl_err = 1'b1;
            end
        end
        if (new_tag >= 0) tags.push_back(new_tag);
    endtask

    // Monitor: samples on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (in_reset) begin
            chk("rst_s_ready",  s_ready,  0);
            chk("rst_s_rvalid", s_rvalid, 0);
            chk("rst_m_valid",  m_valid,  0);
            chk("rst_m_wvalid", m_wvalid, 0);
            chk("rst_err",      err,      0);
        end else begin
            chk("err",      err,      exp_err);
            chk("m_valid",  m_valid,  exp_mv);
            chk("m_wvalid", m_wvalid, exp_mwv);
            if (m_valid && m_ready) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", 1, 0);
                end else begin
                    ce = cmd_q.pop_front();
                    chk("cmd_cycle",   cyc,        ce.cyc);
                    chk("cmd_s_ready", s_ready,    1 << ce.id);
                    chk("cmd_rw",      m_rw,       ce.rw);
                    chk("cmd_accum",   m_accum_en, ce.acc);
                    chk("cmd_mask",    m_mask,     ce.mask);
                    chk("cmd_addr",    m_addr,     ce.addr);
                end
            end else begin
                chk("s_ready_idle", s_ready, 0);
            end
            if (m_wvalid && m_wready) begin
                if (wr_q.size() == 0) begin
                    chk("wdata_unexpected", 1, 0);
                end else begin
                    be = wr_q.pop_front();
                    chk("wdata_cycle", cyc,      be.cyc);
                    chk("s_wready",    s_wready, 1 << be.id);
                    chk("m_wdata",     m_wdata,  be.data);
                end
            end
            if (s_rvalid != '0) begin
                if (rd_q.size() == 0) begin
                    chk("rvalid_unexpected", s_rvalid, 0);
                end else begin
                    be = rd_q.pop_front();
                    chk("rd_cycle", cyc,      be.cyc);
                    chk("s_rvalid", s_rvalid, 1 << be.id);
                    chk("s_rdata",  s_rdata,  be.data);
                end
            end
            chk("cmd_missed", cmd_q.size(), 0);
            chk("wr_missed",  wr_q.size(),  0);
            chk("rd_missed",  rd_q.size(),  0);
            cmd_q.delete();
            wr_q.delete();
            rd_q.delete();
        end
    end

    function automatic bit agents_idle();
        bit idle;
        idle = (tags.size() == 0) && !mdl_locked;
        for (int i = 0; i < NR; i++) if (pend[i] || wpend[i]) idle = 1'b0;
        return idle;
    endfunction

    initial begin
        int n;
        rstn       = 1'b0;
        in_reset   = 1'b1;
        rst_req    = 1'b1;
        cyc        = 0;
        s_valid    = '0;
        s_rw       = '0;
        s_accum_en = '0;
        s_mask     = '0;
        s_addr     = '0;
        s_wvalid   = '0;
        s_wdata    = '0;
        m_ready    = 1'b0;
        m_wready   = 1'b0;
        m_rvalid   = 1'b0;
        m_rdata    = '0;
        force_bad  = 1'b0;
        exp_err    = 1'b0;
        exp_mv     = 1'b0;
        exp_mwv    = 1'b0;
        p_cmd      = 40;
        p_ret      = 30;
        p_rd       = 50;
        for (int i = 0; i < NR; i++) begin
            pend[i]   = 1'b0;
            c_rw[i]   = 1'b0;
            c_acc[i]  = 1'b0;
            c_mask[i] = '0;
            c_addr[i] = '0;
            c_wd[i]   = '0;
            wdly[i]   = 0;
        end
        model_reset();

        repeat (3) step();
        rst_req = 1'b0;
        repeat (1500) step();

        // Reset in the middle of traffic
        rst_req = 1'b1;
        repeat (2) step();
        rst_req = 1'b0;

        // Read-heavy with slow returns so the tag FIFO fills up
        p_ret = 5;
        p_rd  = 70;
        repeat (1500) step();

        // Drain everything outstanding
        p_cmd = 0;
        p_ret = 100;
        n = 0;
        while (!agents_idle() && n < 500) begin
            step();
            n++;
        end
        total++;
        if (!agents_idle()) begin
            bad++;
            $display("FAIL drain_timeout cyc=%0d got=busy exp=idle", cyc);
        end

        // Spurious read return with nothing outstanding
        force_bad = 1'b1;
        step();
        force_bad = 1'b0;
        repeat (5) step();

        // Reset clears the sticky error, then some more traffic
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        p_cmd = 40;
        p_ret = 30;
        p_rd  = 50;
        repeat (300) step();

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
